// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: default widths, jump-control encodings
// and the sequencing state type.
package fetch_unit_pkg;
    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 9;
    localparam int OFF_W_DEF   = 8;
    localparam int RETIRED_W   = 16;

    localparam logic [1:0] JUMP_SEQ = 2'b00;
    localparam logic [1:0] JUMP_REL = 2'b01;
    localparam logic [1:0] JUMP_REG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Combinational next-PC selection for the running state. All arithmetic wraps
// modulo 2^PC_W; the reserved jump code 10 falls through to sequential.
module next_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             hold,
    input  logic             branch,
    input  logic             cond,
    input  logic [1:0]       jump,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  jr_target,
    output logic [PC_W-1:0]  next_pc
);
    logic [PC_W-1:0] off_ext;

    // Size cast of a signed operand sign-extends to the PC width.
    assign off_ext = PC_W'($signed(offset));

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (hold) begin
            next_pc = pc;
        end else if (jump == JUMP_REG) begin
            next_pc = jr_target;
        end else if ((jump == JUMP_REL) || (branch && cond)) begin
            next_pc = pc + off_ext;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/DONE control, program counter and
// retired-instruction counter, addressing a synchronous instruction ROM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OFF_W   = OFF_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_W-1:0]      start_addr,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 branch,
    input  logic [1:0]           jump,
    input  logic                 cond,
    input  logic [OFF_W-1:0]     offset,
    input  logic [PC_W-1:0]      jr_target,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    output logic [PC_W-1:0]      pc,
    output logic                 busy,
    output logic                 done,
    output logic [RETIRED_W-1:0] retired
);
    fetch_state_e         state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      run_next_pc;
    logic [RETIRED_W-1:0] retired_q, retired_d;

    next_pc_gen #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next_pc_gen (
        .pc        (pc_q),
        .hold      (halt | stall),
        .branch    (branch),
        .cond      (cond),
        .jump      (jump),
        .offset    (offset),
        .jr_target (jr_target),
        .next_pc   (run_next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pc_d      = start_addr;
                    retired_d = '0;
                end
            end
            ST_RUN: begin
                pc_d = run_next_pc;
                if (halt) begin
                    state_d = ST_DONE;
                end else if (!stall && (retired_q != '1)) begin
                    retired_d = retired_q + RETIRED_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    // The ROM registers this address, so its data lines up with pc next cycle.
    assign imem_addr   = rst_n ? pc_d : '0;
    assign instr_valid = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign instr       = instr_valid ? imem_data : '0;
    assign pc          = pc_q;
    assign retired     = retired_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10, program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 9, instruction width; opcode for the main decoder is instr[INSTR_W-1:INSTR_W-6].
REQ-003 Parameter OFF_W, default 8, signed branch/jump offset width.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  begin execution at start_addr; sampled only in IDLE.
REQ-008 start_addr  in  PC_W  first fetch address.
REQ-009 stall  in  1  hold PC and current instruction.
REQ-010 halt  in  1  end execution; sampled only in RUN.
REQ-011 branch  in  1  decoder Branch control for the current instruction.
REQ-012 jump  in  2  decoder Jump control: 00 sequential, 01 relative jump, 11 register jump, 10 reserved.
REQ-013 cond  in  1  ALU branch condition; taken = branch & cond.
REQ-014 offset  in  OFF_W  signed PC-relative displacement.
REQ-015 jr_target  in  PC_W  absolute target for register jump.
REQ-016 imem_addr  out  PC_W  instruction memory address, combinational next-PC.
REQ-017 imem_data  in  INSTR_W  synchronous ROM output, valid one cycle after imem_addr.
REQ-018 instr  out  INSTR_W  current instruction; imem_data when instr_valid, else 0.
REQ-019 instr_valid  out  1  current instruction is live.
REQ-020 pc  out  PC_W  address of the current instruction.
REQ-021 busy  out  1  high in RUN.
REQ-022 done  out  1  one-cycle pulse on halt.
REQ-023 retired  out  16  count of executed instructions.

Function
REQ-024 FSM states: IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE on halt; DONE -> IDLE unconditionally after one cycle.
REQ-025 In IDLE, imem_addr = start_addr while start is high, else pc; on start, pc loads start_addr, and instr_valid rises the next cycle.
REQ-026 In RUN, instr_valid = 1; zero-bubble redirect: next-PC is computed combinationally from the current instruction's controls.
REQ-027 Next-PC priority: halt -> pc held; stall -> pc; jump=11 -> jr_target; jump=01 -> pc + sext(offset); branch&cond -> pc + sext(offset); else pc + 1.
REQ-028 jump=10 is treated as sequential (pc + 1).
REQ-029 All PC arithmetic is modulo 2^PC_W, so wrap-around from the maximum address to 0 is legal in both directions.
REQ-030 stall holds pc and drives imem_addr = pc, so instr is re-presented unchanged; retired does not increment.
REQ-031 retired increments by 1 per RUN cycle with !stall and !halt, saturates at 16'hFFFF, and clears on start.
REQ-032 halt has priority over stall, branch and jump in the same cycle: pc is frozen, instr_valid falls the next cycle, and done pulses in DONE.
REQ-033 start in RUN or DONE is ignored, and halt in IDLE is ignored.

Reset
REQ-034 rst_n low forces, asynchronously, state = IDLE, pc = 0, instr_valid = 0, busy = 0, done = 0, retired = 0, and imem_addr = 0.
REQ-035 Reset asserted mid-RUN abandons execution immediately, and no done pulse is produced.

Structure
REQ-036 A shared package holds PC_W, INSTR_W, OFF_W defaults, the JUMP_SEQ/JUMP_REL/JUMP_REG encodings (00/01/11), and the fetch state enum.
REQ-037 Next-PC selection is a combinational sub-module named next_pc_gen, and the FSM, pc register and counter stay in fetch_unit.

Verification
REQ-038 The bench shall cover the sequential case: start_addr=0x010 with no controls gives pc 0x010, 0x011, 0x012 on consecutive cycles with instr_valid=1 from the cycle after start.
REQ-039 The bench shall cover branches: at pc=0x020, branch=1, cond=1, offset=-4 gives next pc 0x01C; cond=0 gives next pc 0x021.
REQ-040 The bench shall cover jumps: jump=11 with jr_target=0x3FF gives pc 0x3FF, then jump=00 gives next pc 0x000 (wrap); jump=01 with offset=+8 at 0x3FC gives 0x004.
REQ-041 The bench shall cover stall: stall high for 3 cycles at pc=0x040 holds pc=0x040 and instr constant with retired unchanged, and release resumes at 0x041.
REQ-042 The bench shall cover halt: halt with branch taken at pc=0x050 gives done=1 for exactly one cycle, pc remains 0x050, and busy=0 and state IDLE two cycles later.
REQ-043 The bench shall cover reset: rst_n pulsed low mid-RUN at pc=0x077 immediately gives pc=0, instr_valid=0 and retired=0, and a subsequent start restarts cleanly.
